// File: rtl/demux_buffered.sv
// ---------------------------------------------------------------------------
// demux_buffered
//   Registered 1:2 demultiplexer with a stream handshake. Each word accepted
//   on the input stream is pushed into one of two per-destination FIFOs,
//   which are selected by in_control. Each FIFO drains independently through
//   its own valid/ready channel.
//
// Ports
//   clk         in   1      single clock, rising edge
//   res         in   1      asynchronous active-high reset, clears all state
//   in_valid    in   1      producer has a word
//   in_ready    out  1      selected channel has room (count != DEPTH)
//   in_data     in   WIDTH  word to route
//   in_control  in   1      route select: 0 -> channel 0, 1 -> channel 1
//   outN_valid  out  1      channel N FIFO non-empty
//   outN_ready  in   1      consumer N takes the head word
//   outN_data   out  WIDTH  channel N head word
//   outN_count  out  CW     channel N occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module demux_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_control,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [CW-1:0]    out0_count,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    out1_count
);

    localparam int PW = $clog2(DEPTH);

    // Storage and per-channel state; index 0/1 is the channel number.
    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];

    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic [1:0]       out_ready_s;

    // Handshake decode and next-state for pointers and occupancy counts.
    always_comb begin
        out_ready_s = {out1_ready, out0_ready};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pop_s       = 2'b00;

        // Only registered counts feed in_ready: a pop in the same cycle does
        // not make room for a push into a full channel.
        in_ready  = (in_control ? cnt_q[1] : cnt_q[0]) != CW'(DEPTH);
        push_s[0] = in_valid & in_ready & ~in_control;
        push_s[1] = in_valid & in_ready &  in_control;

        for (int c = 0; c < 2; c++) begin
            pop_s[c]    = (cnt_q[c] != '0) & out_ready_s[c];
            // DEPTH is a power of two, so natural PW-bit overflow wraps.
            wr_ptr_d[c] = push_s[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = pop_s[c]  ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
            case ({push_s[c], pop_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    // State registers and FIFO storage; reset clears every entry as well.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
                if (push_s[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= in_data;
                end
            end
        end
    end

    // Outputs come purely from registered state; no path from in_* to out*.
    assign out0_valid = cnt_q[0] != '0;
    assign out1_valid = cnt_q[1] != '0;
    assign out0_data  = mem_q[0][rd_ptr_q[0]];
    assign out1_data  = mem_q[1][rd_ptr_q[1]];
    assign out0_count = cnt_q[0];
    assign out1_count = cnt_q[1];

endmodule

// File: tb/tb_demux_buffered.sv
// ---------------------------------------------------------------------------
// tb_demux_buffered
//   Self-checking bench for demux_buffered. A queue-based reference model of
//   the two channel FIFOs is advanced at every rising edge; directed scenarios
//   and a randomized run compare the DUT against it and against constants.
// ---------------------------------------------------------------------------
module tb_demux_buffered;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             res;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_control;
    logic             out0_valid, out1_valid;
    logic             out0_ready, out1_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [CW-1:0]    out0_count, out1_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one queue per channel.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .res        (res),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_control (in_control),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and apply the same transfer to the model.
    task automatic tick(output bit acc);
        bit p0, p1;
        acc = in_valid && ((in_control ? q1.size() : q0.size()) < DEPTH);
        p0  = out0_ready && (q0.size() != 0);
        p1  = out1_ready && (q1.size() != 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (in_control) q1.push_back(in_data);
            else            q0.push_back(in_data);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        in_control = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        idle_inputs();
        #12;
        tests_run++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b%b expected 00", out1_valid, out0_valid); end
        tests_run++; if (out0_data !== '0 || out1_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h %h expected 0 0", out0_data, out1_data); end
        tests_run++; if (out0_count !== '0 || out1_count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d %0d expected 0 0", out0_count, out1_count); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        res = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic test_single_route();
        bit acc;
        in_valid = 1'b1; in_control = 1'b0; in_data = 32'h0000_00A5;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
        tick(acc);
        in_valid = 1'b0;
        tests_run++; if (out0_valid !== 1'b1 || out0_data !== 32'h0000_00A5) begin tests_failed++; $display("FAIL single_out0: got v=%b d=%h expected v=1 d=000000a5", out0_valid, out0_data); end
        tests_run++; if (out1_valid !== 1'b0) begin tests_failed++; $display("FAIL single_out1_valid: got %b expected 0", out1_valid); end
        tests_run++; if (out0_count !== CW'(1)) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", out0_count); end
        out0_ready = 1'b1;
        tick(acc);
        out0_ready = 1'b0;
        tests_run++; if (out0_valid !== 1'b0 || out0_count !== '0) begin tests_failed++; $display("FAIL single_drain: got v=%b c=%0d expected v=0 c=0", out0_valid, out0_count); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        in_valid = 1'b1; in_control = 1'b0;
        in_data = 32'hAAAA_0001; tick(acc);
        in_data = 32'hAAAA_0002; tick(acc);
        in_valid = 1'b0;
        tests_run++; if (out0_count !== CW'(2)) begin tests_failed++; $display("FAIL rstmid_fill: got %0d expected 2", out0_count); end
        #2 res = 1'b1;
        q0.delete(); q1.delete();
        #1;
        tests_run++; if (out0_valid !== 1'b0 || out0_count !== '0 || out0_data !== '0) begin tests_failed++; $display("FAIL rstmid_clear: got v=%b c=%0d d=%h expected v=0 c=0 d=0", out0_valid, out0_count, out0_data); end
        res = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0077;
        tick(acc);
        in_valid = 1'b0;
        tests_run++; if (out0_count !== CW'(1) || out0_data !== 32'h0000_0077) begin tests_failed++; $display("FAIL rstmid_alone: got c=%0d d=%h expected c=1 d=00000077", out0_count, out0_data); end
        out0_ready = 1'b1; tick(acc); out0_ready = 1'b0;
        tests_run++; if (out0_count !== '0) begin tests_failed++; $display("FAIL rstmid_drain: got %0d expected 0", out0_count); end
    endtask

    task automatic test_full_backpressure();
        bit acc;
        logic [WIDTH-1:0] exp_order [3];
        exp_order[0] = 32'h11; exp_order[1] = 32'h22; exp_order[2] = 32'h33;
        in_valid = 1'b1; in_control = 1'b1;
        in_data = 32'h11; tick(acc);
        in_data = 32'h22; tick(acc);
        in_data = 32'h33;
        #1;
        tests_run++; if (in_ready !== 1'b0 || out1_count !== CW'(2)) begin tests_failed++; $display("FAIL full_block: got r=%b c=%0d expected r=0 c=2", in_ready, out1_count); end
        tick(acc);
        tests_run++; if (acc !== 1'b0 || out1_count !== CW'(2)) begin tests_failed++; $display("FAIL full_hold: got c=%0d expected c=2", out1_count); end
        out1_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_pop_same_cycle: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (out1_valid !== 1'b1 || out1_data !== exp_order[i]) begin tests_failed++; $display("FAIL full_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, out1_valid, out1_data, exp_order[i]); end
            tick(acc);
            if (i == 0) begin
                tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_reopen: got %b expected 1", in_ready); end
            end
            if (acc) in_valid = 1'b0;
        end
        out1_ready = 1'b0;
        tests_run++; if (out1_count !== '0 || in_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drain: got c=%0d pending=%b expected c=0 pending=0", out1_count, in_valid); end
    endtask

    task automatic test_cross_channel();
        bit acc;
        in_valid = 1'b1; in_control = 1'b0;
        in_data = 32'hC0; tick(acc);
        in_data = 32'hC1; tick(acc);
        in_valid = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL cross_ch0_full: got %b expected 0", in_ready); end
        in_valid = 1'b1; in_control = 1'b1; in_data = 32'hBEEF;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL cross_in_ready: got %b expected 1", in_ready); end
        tick(acc);
        in_valid = 1'b0;
        tests_run++; if (out1_valid !== 1'b1 || out1_data !== 32'hBEEF) begin tests_failed++; $display("FAIL cross_out1: got v=%b d=%h expected v=1 d=0000beef", out1_valid, out1_data); end
        tests_run++; if (out0_count !== CW'(2) || out0_data !== 32'hC0) begin tests_failed++; $display("FAIL cross_ch0_kept: got c=%0d d=%h expected c=2 d=000000c0", out0_count, out0_data); end
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick(acc); tick(acc);
        out0_ready = 1'b0; out1_ready = 1'b0;
        tests_run++; if (out0_count !== '0 || out1_count !== '0) begin tests_failed++; $display("FAIL cross_drain: got %0d %0d expected 0 0", out0_count, out1_count); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        out0_ready = 1'b1; in_control = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = WIDTH'(i);
            if (i > 1) begin
                tests_run++; if (out0_data !== WIDTH'(i - 1)) begin tests_failed++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, out0_data, WIDTH'(i - 1)); end
            end
            tick(acc);
            tests_run++; if (out0_count !== CW'(1)) begin tests_failed++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, out0_count); end
        end
        in_valid = 1'b0;
        tests_run++; if (out0_data !== 32'h8) begin tests_failed++; $display("FAIL b2b_last: got %h expected 00000008", out0_data); end
        tick(acc);
        out0_ready = 1'b0;
        tests_run++; if (out0_count !== '0 || out0_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty: got c=%0d v=%b expected c=0 v=0", out0_count, out0_valid); end
    endtask

    task automatic test_random();
        bit acc;
        int accepted = 0;
        int popped   = 0;
        int cycles   = 0;
        int exp_ready;
        in_valid = 1'b0;
        while ((accepted < 200 || q0.size() != 0 || q1.size() != 0) && cycles < 5000) begin
            if (!in_valid) begin
                if (accepted < 200 && $urandom_range(3, 0) != 0) begin
                    in_valid   = 1'b1;
                    in_control = 1'($urandom_range(1, 0));
                    in_data    = $urandom;
                end
            end
            out0_ready = ($urandom_range(2, 0) != 0) || (accepted >= 200);
            out1_ready = ($urandom_range(2, 0) != 0) || (accepted >= 200);
            #1;
            exp_ready = ((in_control ? q1.size() : q0.size()) < DEPTH) ? 1 : 0;
            tests_run++; if (int'(in_ready) !== exp_ready) begin tests_failed++; $display("FAIL rand_in_ready@%0d: got %b expected %0d", cycles, in_ready, exp_ready); end
            if (out0_ready && q0.size() != 0) begin
                popped++;
                tests_run++; if (out0_valid !== 1'b1 || out0_data !== q0[0]) begin tests_failed++; $display("FAIL rand_out0@%0d: got v=%b d=%h expected v=1 d=%h", cycles, out0_valid, out0_data, q0[0]); end
            end
            if (out1_ready && q1.size() != 0) begin
                popped++;
                tests_run++; if (out1_valid !== 1'b1 || out1_data !== q1[0]) begin tests_failed++; $display("FAIL rand_out1@%0d: got v=%b d=%h expected v=1 d=%h", cycles, out1_valid, out1_data, q1[0]); end
            end
            tick(acc);
            if (acc) begin
                accepted++;
                in_valid = 1'b0;
            end
            cycles++;
            tests_run++; if (int'(out0_count) !== q0.size() || int'(out1_count) !== q1.size()) begin tests_failed++; $display("FAIL rand_count@%0d: got %0d %0d expected %0d %0d", cycles, out0_count, out1_count, q0.size(), q1.size()); end
            tests_run++; if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin tests_failed++; $display("FAIL rand_valid@%0d: got %b%b expected %b%b", cycles, out1_valid, out0_valid, q1.size() != 0, q0.size() != 0); end
            tests_run++; if (int'(out0_count) > DEPTH || int'(out1_count) > DEPTH) begin tests_failed++; $display("FAIL rand_overflow@%0d: got %0d %0d limit %0d", cycles, out0_count, out1_count, DEPTH); end
        end
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        tests_run++; if (cycles >= 5000) begin tests_failed++; $display("FAIL rand_timeout: got %0d cycles limit 5000", cycles); end
        tests_run++; if (accepted != 200 || popped != 200) begin tests_failed++; $display("FAIL rand_totals: got acc=%0d pop=%0d expected 200 200", accepted, popped); end
        tests_run++; if (out0_count !== '0 || out1_count !== '0) begin tests_failed++; $display("FAIL rand_final_empty: got %0d %0d expected 0 0", out0_count, out1_count); end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_reset_mid();
        test_full_backpressure();
        test_cross_channel();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
